// File: rtl/pit_bus_controller.sv
// 8254 bus-side controller: control words, count bytes,
// latch commands and read-back data for counters 0..2.
module pit_bus_controller #(
  parameter bit         IGNORE_UNPROG = 1'b1,
  parameter logic [7:0] IDLE_DOUT     = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [7:0]  din,
  input  logic [47:0] ol_in,
  input  logic [23:0] status_in,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic [7:0]  cw_data,
  output logic [2:0]  cw_load,
  output logic [7:0]  cnt_data,
  output logic [2:0]  lsb_load,
  output logic [2:0]  msb_load,
  output logic [2:0]  count_commit,
  output logic [2:0]  latch_count,
  output logic [2:0]  latch_status,
  output logic [2:0]  latch_release
);

  logic [2:0][1:0] rw_q, rw_n;
  logic [2:0] wt_q, wt_n;
  logic [2:0] rt_q, rt_n;
  logic [2:0] cl_q, cl_n;
  logic [2:0] sp_q, sp_n;

  logic [7:0] dout_n, cwd_n, cnd_n;
  logic       dv_n;
  logic [2:0] cwl_n, lsb_n, msb_n, cc_n;
  logic [2:0] lc_n, ls_n, lr_n;

  logic wr_cw, wr_cnt, rd_cw, rd_cnt;

  assign wr_cw  = wr_en && (addr == 2'b11);
  assign wr_cnt = wr_en && (addr != 2'b11);
  assign rd_cw  = !wr_en && rd_en && (addr == 2'b11);
  assign rd_cnt = !wr_en && rd_en && (addr != 2'b11);

  // Decode the bus strobe into next-state and next pulses
  always_comb begin
    int         c;
    int         sc;
    logic [1:0] md;
    logic       done;
    rw_n   = rw_q;
    wt_n   = wt_q;
    rt_n   = rt_q;
    cl_n   = cl_q;
    sp_n   = sp_q;
    dout_n = dout;
    dv_n   = 1'b0;
    cwd_n  = cw_data;
    cnd_n  = cnt_data;
    cwl_n  = '0;
    lsb_n  = '0;
    msb_n  = '0;
    cc_n   = '0;
    lc_n   = '0;
    ls_n   = '0;
    lr_n   = '0;
    c      = int'(addr);
    sc     = int'(din[7:6]);
    md     = 2'b00;
    done   = 1'b0;
    unique case (1'b1)
      wr_cw: begin
        if (sc == 3) begin
          for (int i = 0; i < 3; i++) begin
            if (din[1+i]) begin
              if (!din[5] && !cl_q[i]) begin
                lc_n[i] = 1'b1;
                cl_n[i] = 1'b1;
              end
              if (!din[4] && !sp_q[i]) begin
                ls_n[i] = 1'b1;
                sp_n[i] = 1'b1;
              end
            end
          end
        end else if (din[5:4] == 2'b00) begin
          if (!cl_q[sc]) begin
            lc_n[sc] = 1'b1;
            cl_n[sc] = 1'b1;
          end
        end else begin
          cwl_n[sc] = 1'b1;
          cwd_n     = din;
          rw_n[sc]  = din[5:4];
          wt_n[sc]  = 1'b0;
          rt_n[sc]  = 1'b0;
          cl_n[sc]  = 1'b0;
          sp_n[sc]  = 1'b0;
        end
      end
      wr_cnt: begin
        md = rw_q[c];
        if (md == 2'b00 && !IGNORE_UNPROG) md = 2'b01;
        cnd_n = din;
        case (md)
          2'b01: begin
            lsb_n[c] = 1'b1;
            cc_n[c]  = 1'b1;
          end
          2'b10: begin
            msb_n[c] = 1'b1;
            cc_n[c]  = 1'b1;
          end
          2'b11: begin
            if (!wt_q[c]) begin
              lsb_n[c] = 1'b1;
              wt_n[c]  = 1'b1;
            end else begin
              msb_n[c] = 1'b1;
              cc_n[c]  = 1'b1;
              wt_n[c]  = 1'b0;
            end
          end
          default: ;
        endcase
      end
      rd_cw: begin
        dv_n   = 1'b1;
        dout_n = IDLE_DOUT;
      end
      rd_cnt: begin
        md = rw_q[c];
        if (md == 2'b00 && !IGNORE_UNPROG) md = 2'b01;
        dv_n = 1'b1;
        if (md == 2'b00) begin
          dout_n = 8'h00;
        end else if (sp_q[c]) begin
          dout_n  = status_in[c*8 +: 8];
          sp_n[c] = 1'b0;
        end else begin
          case (md)
            2'b01: begin
              dout_n = ol_in[c*16 +: 8];
              done   = 1'b1;
            end
            2'b10: begin
              dout_n = ol_in[c*16+8 +: 8];
              done   = 1'b1;
            end
            default: begin
              if (!rt_q[c]) begin
                dout_n  = ol_in[c*16 +: 8];
                rt_n[c] = 1'b1;
              end else begin
                dout_n  = ol_in[c*16+8 +: 8];
                rt_n[c] = 1'b0;
                done    = 1'b1;
              end
            end
          endcase
          if (done && cl_q[c]) begin
            lr_n[c] = 1'b1;
            cl_n[c] = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Register state and all outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rw_q          <= '0;
      wt_q          <= '0;
      rt_q          <= '0;
      cl_q          <= '0;
      sp_q          <= '0;
      dout          <= IDLE_DOUT;
      dout_valid    <= 1'b0;
      cw_data       <= '0;
      cnt_data      <= '0;
      cw_load       <= '0;
      lsb_load      <= '0;
      msb_load      <= '0;
      count_commit  <= '0;
      latch_count   <= '0;
      latch_status  <= '0;
      latch_release <= '0;
    end else begin
      rw_q          <= rw_n;
      wt_q          <= wt_n;
      rt_q          <= rt_n;
      cl_q          <= cl_n;
      sp_q          <= sp_n;
      dout          <= dout_n;
      dout_valid    <= dv_n;
      cw_data       <= cwd_n;
      cnt_data      <= cnd_n;
      cw_load       <= cwl_n;
      lsb_load      <= lsb_n;
      msb_load      <= msb_n;
      count_commit  <= cc_n;
      latch_count   <= lc_n;
      latch_status  <= ls_n;
      latch_release <= lr_n;
    end
  end

endmodule

// File: doc/pit_bus_controller.md
Name: pit_bus_controller

Overview:
- Bus-side read/write controller for the three-counter 8254 timer.
- Decodes addr/din/wr_en/rd_en into control-word loads, LSB/MSB count-byte sequencing, counter-latch and read-back commands for counters 0..2.
- Multiplexes latched status and output-latch bytes back onto the data bus.
- Sits between the CPU interface and the three control-logic/counting-element pairs; owns every byte-order flip-flop and latch-pending flag.

Parameters:
- IGNORE_UNPROG, 1, when 1 counter-port reads/writes to a counter whose RW field is 00 (unprogrammed since reset) are dropped (read returns 8'h00).
- IDLE_DOUT, 8'h00, dout value after reset and for address 3 reads.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  one-cycle write strobe
- rd_en  in  1  one-cycle read strobe
- addr  in  2  00/01/10 = counter 0/1/2, 11 = control word register
- din  in  8  write data
- ol_in  in  48  output latches, counter i at [16i+15:16i]
- status_in  in  24  status bytes, counter i at [8i+7:8i]
- dout  out  8  registered read data
- dout_valid  out  1  pulse, dout valid
- cw_data  out  8  control word to counters
- cw_load  out  3  one-hot pulse, load cw_data into counter i
- cnt_data  out  8  count byte to counters
- lsb_load  out  3  pulse, cnt_data is the LSB of counter i's initial count
- msb_load  out  3  pulse, cnt_data is the MSB of counter i's initial count
- count_commit  out  3  pulse, counter i's initial count is complete
- latch_count  out  3  pulse, freeze counter i's output latch
- latch_status  out  3  pulse, capture counter i's status
- latch_release  out  3  pulse, counter i's output latch follows the count again

Behaviour:
- Reset (rst_n=0 at clk edge): all pulses 0; dout=IDLE_DOUT; dout_valid=0; cw_data=cnt_data=0; per counter: rw_mode=00, wr_toggle=0, rd_toggle=0, count_latched=0, status_pending=0.
- All outputs are registered. Every response appears exactly one cycle after the strobe.
- If wr_en and rd_en are both high, the write executes and the read is ignored (no dout_valid).
- Write, addr=11, din[7:6] selects counter SC:
  - RW=din[5:4]=00: counter-latch command. If count_latched[SC]=0, pulse latch_count[SC] and set count_latched; otherwise ignore.
  - RW≠00: pulse cw_load[SC] with cw_data=din. Set rw_mode[SC]=RW. Clear wr_toggle, rd_toggle, count_latched and status_pending for SC.
- Write, addr=11, din[7:6]=11: read-back command.
  - Counter i is selected when din[1+i]=1.
  - If din[5]=0 and count_latched[i]=0: pulse latch_count[i] and set count_latched[i].
  - If din[4]=0 and status_pending[i]=0: pulse latch_status[i] and set status_pending[i].
  - Multiple counters latch in the same cycle.
- Write, counter address i:
  - rw_mode 01: lsb_load[i] and count_commit[i].
  - rw_mode 10: msb_load[i] and count_commit[i].
  - rw_mode 11: toggle=0 gives lsb_load[i] then sets toggle; toggle=1 gives msb_load[i] plus count_commit[i] then clears toggle.
  - cnt_data=din in every case.
- Read, counter address i, in priority order:
  1. status_pending=1: dout=status_in[i], clear status_pending.
  2. Otherwise by rw_mode:
     - 01: dout=LSB of ol_in[i].
     - 10: dout=MSB of ol_in[i].
     - 11: rd_toggle=0 gives the LSB and sets rd_toggle; rd_toggle=1 gives the MSB and clears rd_toggle.
  3. Completing the count read (mode 01/10 single read, or the mode-11 MSB read) while count_latched=1 pulses latch_release[i] and clears count_latched.
- Read, addr=11: dout=IDLE_DOUT with dout_valid=1; no state change.
- Unprogrammed counter (rw_mode 00) with IGNORE_UNPROG=1:
  - Write: no pulses.
  - Read: dout=8'h00 with dout_valid=1.
- Reset mid-sequence, e.g. after an LSB write in mode 11, discards the partial count. No commit is issued.

Test Plan:
- Write 8'h34 to addr 3, then 8'h10 and 8'h27 to addr 0 → cw_load=001 with cw_data=34; then lsb_load[0] with cnt_data=10; then msb_load[0] plus count_commit[0] with cnt_data=27.
- Write 8'h50 to addr 3, then 8'h05 to addr 1 → one lsb_load[1] and count_commit[1] in the same cycle.
- Counter 2 in mode 11, ol_in[47:32]=16'hABCD: write 8'h80 to addr 3 twice, then read addr 2 twice → latch_count[2] pulses once only; reads give CD then AB; latch_release[2] pulses with the AB read.
- Write read-back 8'hC2 to addr 3 (status and count of counter 0), status_in[7:0]=8'h36, ol_in=16'h1234, rw=11 → three reads give 36, 34, 12; then latch_release[0].
- wr_en and rd_en high together on addr 0 → write executes; dout_valid stays 0.
- Assert rst_n=0 after the first LSB write in mode 11, reprogram, then write two bytes → lsb then msb sequence restarts; no stray commit.
